// File: rtl/traffic_phase_scheduler_if.sv
// Purpose: bundles the scheduler's time base, requests, preemption and lamp outputs.
// Latency: n/a (signal bundle only).
// Backpressure: none; all inputs are levels or strobes sampled every cycle.
//
// Signals:
//   tick          one-cycle time-base strobe
//   req           per-approach vehicle-presence level
//   preempt_valid emergency preemption active (level)
//   preempt_id    approach to force green; ignored when >= N_APPR
//   green/amber   lamp drives, at most one bit set each
//   red           ~(green|amber)
//   cur_phase     last granted approach
//   idle          all red, clearance expired, nobody waiting
//   phase_start   one-cycle pulse on the first cycle of each green
//
// master: the side producing tick/req/preempt and consuming lamps.
// slave : the scheduler itself.
interface traffic_phase_scheduler_if #(
  parameter int N_APPR = 4
) ();
  localparam int ID_W = (N_APPR > 1) ? $clog2(N_APPR) : 1;

  logic              tick;
  logic [N_APPR-1:0] req;
  logic              preempt_valid;
  logic [ID_W-1:0]   preempt_id;
  logic [N_APPR-1:0] green;
  logic [N_APPR-1:0] amber;
  logic [N_APPR-1:0] red;
  logic [ID_W-1:0]   cur_phase;
  logic              idle;
  logic              phase_start;

  modport master (
    output tick, req, preempt_valid, preempt_id,
    input  green, amber, red, cur_phase, idle, phase_start
  );

  modport slave (
    input  tick, req, preempt_valid, preempt_id,
    output green, amber, red, cur_phase, idle, phase_start
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Purpose: grants a single green among N_APPR approaches, sequencing GREEN/AMBER/ALL_RED.
// Latency: one clk edge from any qualifying input to the new state; outputs registered.
// Backpressure: none; requests are levels held by the sensor front end until served.
//
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       traffic_phase_scheduler_if.slave: tick, req, preempt_valid,
//             preempt_id in; green, amber, red, cur_phase, idle, phase_start out
module traffic_phase_scheduler #(
  parameter int N_APPR    = 4,
  parameter int CNT_W     = 5,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 15,
  parameter int AMBER_T   = 3,
  parameter int ALL_RED_T = 2
) (
  input logic                      clk,
  input logic                      rst,
  traffic_phase_scheduler_if.slave bus
);

  localparam int ID_W = (N_APPR > 1) ? $clog2(N_APPR) : 1;

  localparam logic [CNT_W-1:0] MIN_G  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_G  = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] AMB_T  = CNT_W'(AMBER_T);
  localparam logic [CNT_W-1:0] AMB_M1 = CNT_W'(AMBER_T - 1);
  localparam logic [CNT_W-1:0] AR_T   = CNT_W'(ALL_RED_T);
  localparam logic [CNT_W-1:0] AR_M1  = CNT_W'(ALL_RED_T - 1);

  // Catch illegal parameter sets at elaboration instead of producing odd timing.
  if (N_APPR < 2 || MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN ||
      MAX_GREEN >= (1 << CNT_W) || AMBER_T < 1 || AMBER_T >= (1 << CNT_W) ||
      ALL_RED_T < 1 || ALL_RED_T >= (1 << CNT_W)) begin : g_bad_param
    $error("traffic_phase_scheduler: illegal timing parameters");
  end

  typedef enum logic [1:0] {
    ST_GREEN   = 2'd0,
    ST_AMBER   = 2'd1,
    ST_ALL_RED = 2'd2
  } state_t;

  state_t            state;
  state_t            nstate;
  logic [CNT_W-1:0]  t;
  logic [ID_W-1:0]   cur;
  logic [ID_W-1:0]   ncur;

  logic [N_APPR-1:0] green_q;
  logic [N_APPR-1:0] amber_q;
  logic [N_APPR-1:0] red_q;
  logic              idle_q;
  logic              start_q;

  logic              pre_ok;
  logic [N_APPR-1:0] cur_oh;
  logic [N_APPR-1:0] next_oh;
  logic [N_APPR-1:0] others;
  logic              win_vld;
  logic [ID_W-1:0]   win_id;
  int                idx;

  logic [CNT_W-1:0]  t_inc;
  logic [CNT_W-1:0]  t_lim;
  logic [CNT_W-1:0]  g_cnt;
  logic              amb_done;
  logic              clr_done;
  logic              green_exit;
  logic              idle_nxt;

  // Out-of-range preempt ids are treated as no preemption at all.
  assign pre_ok = bus.preempt_valid && (int'(bus.preempt_id) < N_APPR);

  assign cur_oh  = N_APPR'(1) << cur;
  assign next_oh = N_APPR'(1) << ncur;
  assign others  = bus.req & ~cur_oh;

  // Round-robin search from cur+1 around to cur. The loop runs from the
  // farthest offset down to the nearest so the closest requester wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = cur;
    idx     = 0;
    if (pre_ok) begin
      win_vld = 1'b1;
      win_id  = bus.preempt_id;
    end else begin
      for (int k = N_APPR; k >= 1; k--) begin
        idx = int'(cur) + k;
        if (idx >= N_APPR) idx = idx - N_APPR;
        if (bus.req[idx[ID_W-1:0]]) begin
          win_vld = 1'b1;
          win_id  = idx[ID_W-1:0];
        end
      end
    end
  end

  // Timer views. A tick in the current cycle already counts toward the
  // decision taken on this edge, so thresholds compare against t+tick.
  always_comb begin
    t_inc = t + CNT_W'(1);
    case (state)
      ST_GREEN: t_lim = MAX_G;
      ST_AMBER: t_lim = AMB_T;
      default:  t_lim = AR_T;
    endcase
    g_cnt    = (bus.tick && (t < MAX_G)) ? t_inc : t;
    amb_done = bus.tick && (t == AMB_M1);
    // t parks at ALL_RED_T once clearance has run out, so >= means idle.
    clr_done = (t >= AR_T) || (bus.tick && (t == AR_M1));
    green_exit = (g_cnt >= MIN_G) && (others != '0) &&
                 (!bus.req[cur] || (g_cnt >= MAX_G));
  end

  always_comb begin
    nstate   = state;
    ncur     = cur;
    idle_nxt = 1'b0;
    case (state)
      ST_GREEN: begin
        if (pre_ok) begin
          // Preempting another approach skips min green; preempting
          // ourselves pins green and disables max-out.
          if (bus.preempt_id != cur) nstate = ST_AMBER;
        end else if (green_exit) begin
          nstate = ST_AMBER;
        end
      end
      ST_AMBER: begin
        if (amb_done) nstate = ST_ALL_RED;
      end
      ST_ALL_RED: begin
        if (clr_done) begin
          if (win_vld) begin
            nstate = ST_GREEN;
            ncur   = win_id;
          end else begin
            idle_nxt = 1'b1;
          end
        end
      end
      default: nstate = ST_ALL_RED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ALL_RED;
      t       <= '0;
      cur     <= ID_W'(N_APPR - 1);
      green_q <= '0;
      amber_q <= '0;
      red_q   <= '1;
      idle_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state <= nstate;
      cur   <= ncur;
      if (nstate != state) begin
        t <= '0;
      end else if (bus.tick && (t < t_lim)) begin
        t <= t_inc;
      end
      // Lamps decode the state being entered so they line up with it.
      green_q <= (nstate == ST_GREEN) ? next_oh : '0;
      amber_q <= (nstate == ST_AMBER) ? next_oh : '0;
      red_q   <= (nstate == ST_GREEN || nstate == ST_AMBER) ? ~next_oh : '1;
      idle_q  <= idle_nxt;
      start_q <= (state == ST_ALL_RED) && (nstate == ST_GREEN);
    end
  end

  assign bus.green       = green_q;
  assign bus.amber       = amber_q;
  assign bus.red         = red_q;
  assign bus.cur_phase   = cur;
  assign bus.idle        = idle_q;
  assign bus.phase_start = start_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Purpose: self-checking bench for traffic_phase_scheduler against a phase-level model.
// Latency: model updates on the same edge as the DUT; outputs sampled 1 time unit later.
// Backpressure: n/a.
module tb_traffic_phase_scheduler;
  localparam int NA   = 4;
  localparam int MING = 5;
  localparam int MAXG = 15;
  localparam int AMB  = 3;
  localparam int ART  = 2;

  localparam int K_GREEN = 0;
  localparam int K_AMBER = 1;
  localparam int K_RED   = 2;

  localparam logic [15:0] RESET_V = {4'b0000, 4'b0000, 4'b1111, 2'd3, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // Model: which lamp phase we are in, ticks seen in it, last grant.
  int m_kind  = K_RED;
  int m_ticks = 0;
  int m_cur   = NA - 1;
  int m_idle  = 0;
  int m_ps    = 0;

  traffic_phase_scheduler_if #(.N_APPR(NA)) bus ();

  traffic_phase_scheduler #(
    .N_APPR(NA), .CNT_W(5), .MIN_GREEN(MING), .MAX_GREEN(MAXG),
    .AMBER_T(AMB), .ALL_RED_T(ART)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int pick_winner();
    if (bus.preempt_valid) return int'(bus.preempt_id);
    for (int k = 1; k <= NA; k++) begin
      if (bus.req[(m_cur + k) % NA]) return (m_cur + k) % NA;
    end
    return -1;
  endfunction

  task automatic model_step();
    int cnt;
    int eff;
    int w;
    logic [3:0] oh;
    logic [3:0] oth;
    bit leave;
    if (rst) begin
      m_kind = K_RED; m_ticks = 0; m_cur = NA - 1; m_idle = 0; m_ps = 0;
      return;
    end
    cnt = m_ticks + (bus.tick ? 1 : 0);
    m_idle = 0;
    m_ps = 0;
    if (m_kind == K_RED) begin
      if (cnt >= ART) begin
        w = pick_winner();
        if (w >= 0) begin
          m_kind = K_GREEN; m_cur = w; m_ticks = 0; m_ps = 1;
        end else begin
          m_idle = 1; m_ticks = cnt;
        end
      end else begin
        m_ticks = cnt;
      end
    end else if (m_kind == K_GREEN) begin
      eff = (cnt > MAXG) ? MAXG : cnt;
      oh = 4'b0001 << m_cur;
      oth = bus.req & ~oh;
      if (bus.preempt_valid) leave = (int'(bus.preempt_id) != m_cur);
      else leave = (eff >= MING) && (oth != 0) && (!bus.req[m_cur] || eff >= MAXG);
      if (leave) begin
        m_kind = K_AMBER; m_ticks = 0;
      end else begin
        m_ticks = cnt;
      end
    end else begin
      if (cnt >= AMB) begin
        m_kind = K_RED; m_ticks = 0;
      end else begin
        m_ticks = cnt;
      end
    end
  endtask

  function automatic logic [15:0] exp_vec();
    logic [3:0] oh;
    logic [3:0] g;
    logic [3:0] a;
    oh = 4'b0001 << m_cur;
    g = (m_kind == K_GREEN) ? oh : 4'b0000;
    a = (m_kind == K_AMBER) ? oh : 4'b0000;
    return {g, a, ~(g | a), 2'(m_cur), 1'(m_idle), 1'(m_ps)};
  endfunction

  function automatic logic [15:0] obs_vec();
    return {bus.green, bus.amber, bus.red, bus.cur_phase, bus.idle, bus.phase_start};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic bit in_phase(input int kind);
    if (kind == K_GREEN) return bus.green != 0;
    if (kind == K_AMBER) return bus.amber != 0;
    return (bus.green | bus.amber) == 0;
  endfunction

  // Random ticks while the DUT shows the given lamp phase; returns ticks
  // spent there and the number of cycles where DUT and model disagreed.
  task automatic run_phase(input int kind, output int nt, output int mism);
    int n;
    nt = 0; mism = 0; n = 0;
    while (in_phase(kind) && n < 400) begin
      bus.tick = ($urandom_range(0, 2) == 0);
      nt += bus.tick ? 1 : 0;
      cycle();
      if (obs_vec() !== exp_vec()) mism++;
      n++;
    end
    if (n >= 400) mism++;
    bus.tick = 1'b0;
  endtask

  task automatic run_ticks(input int nticks, output int mism);
    int k;
    int n;
    k = 0; n = 0; mism = 0;
    while (k < nticks && n < 40 * nticks + 40) begin
      bus.tick = ($urandom_range(0, 2) == 0);
      k += bus.tick ? 1 : 0;
      cycle();
      if (obs_vec() !== exp_vec()) mism++;
      n++;
    end
    if (k < nticks) mism++;
    bus.tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req = '0; bus.preempt_valid = 1'b0; bus.preempt_id = '0; bus.tick = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.preempt_valid = 1'b0; bus.preempt_id = '0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req = 4'($urandom_range(0, 15));
      bus.tick = 1'($urandom_range(0, 1));
      cycle();
      total++;
      if (obs_vec() !== RESET_V) begin
        bad++; $display("FAIL reset_outputs: got %h want %h", obs_vec(), RESET_V);
      end
    end
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_model: got %h want %h", obs_vec(), exp_vec());
    end
    rst = 1'b0; bus.req = '0; bus.tick = 1'b0;
  endtask

  task automatic test_first_grant();
    int nt, mism, nps, namb, n, k;
    do_reset();
    bus.req = 4'b0001;
    run_phase(K_RED, nt, mism);
    total++;
    if (nt !== 2) begin bad++; $display("FAIL first_grant_ticks: got %0d want 2", nt); end
    total++;
    if (bus.green !== 4'b0001 || bus.phase_start !== 1'b1) begin
      bad++; $display("FAIL first_grant_lamp: got g=%b ps=%b want g=0001 ps=1", bus.green, bus.phase_start);
    end
    nps = 0; namb = 0; k = 0; n = 0;
    while (k < 100 && n < 2000) begin
      bus.tick = ($urandom_range(0, 2) == 0);
      k += bus.tick ? 1 : 0;
      cycle();
      if (obs_vec() !== exp_vec()) mism++;
      nps += bus.phase_start ? 1 : 0;
      namb += (bus.amber != 0) ? 1 : 0;
      n++;
    end
    bus.tick = 1'b0;
    total++;
    if (nps !== 0 || namb !== 0 || bus.green !== 4'b0001) begin
      bad++; $display("FAIL rest_in_green: got ps=%0d amber=%0d g=%b want 0 0 0001", nps, namb, bus.green);
    end
    total++;
    if (mism !== 0) begin bad++; $display("FAIL first_grant_model: got %0d mismatching cycles want 0", mism); end
  endtask

  task automatic test_gap_out();
    int nt, m0, m1, m2, m3, m4, na, nr;
    do_reset();
    bus.req = 4'b0001;
    run_phase(K_RED, nt, m0);
    run_ticks(2, m1);
    bus.req = 4'b0010;
    run_phase(K_GREEN, nt, m2);
    total++;
    if (nt + 2 !== MING) begin bad++; $display("FAIL gap_out_green_ticks: got %0d want %0d", nt + 2, MING); end
    total++;
    if (bus.amber !== 4'b0001) begin bad++; $display("FAIL gap_out_amber: got %b want 0001", bus.amber); end
    run_phase(K_AMBER, na, m3);
    run_phase(K_RED, nr, m4);
    total++;
    if (na !== AMB || nr !== ART) begin
      bad++; $display("FAIL gap_out_amber_red_ticks: got %0d/%0d want %0d/%0d", na, nr, AMB, ART);
    end
    total++;
    if (bus.green !== 4'b0010 || bus.cur_phase !== 2'd1) begin
      bad++; $display("FAIL gap_out_next_green: got g=%b cur=%0d want 0010 1", bus.green, bus.cur_phase);
    end
    total++;
    if (m0 + m1 + m2 + m3 + m4 !== 0) begin
      bad++; $display("FAIL gap_out_model: got %0d mismatching cycles want 0", m0 + m1 + m2 + m3 + m4);
    end
  endtask

  task automatic test_max_out();
    int n0, n1, n2, n3, m, mm;
    do_reset();
    bus.req = 4'b0011;
    mm = 0;
    run_phase(K_RED, n0, m); mm += m;
    run_phase(K_GREEN, n1, m); mm += m;
    total++;
    if (n1 !== MAXG || bus.amber !== 4'b0001) begin
      bad++; $display("FAIL max_out_phase0: got ticks=%0d amber=%b want %0d 0001", n1, bus.amber, MAXG);
    end
    run_phase(K_AMBER, n2, m); mm += m;
    run_phase(K_RED, n3, m); mm += m;
    total++;
    if (bus.green !== 4'b0010) begin bad++; $display("FAIL max_out_next: got %b want 0010", bus.green); end
    run_phase(K_GREEN, n1, m); mm += m;
    total++;
    if (n1 !== MAXG) begin bad++; $display("FAIL max_out_phase1: got %0d want %0d", n1, MAXG); end
    total++;
    if (mm !== 0) begin bad++; $display("FAIL max_out_model: got %0d want 0", mm); end
  endtask

  task automatic test_round_robin();
    int ng, na, nr, m, mm;
    logic [3:0] want;
    do_reset();
    bus.req = 4'b1111;
    mm = 0;
    run_phase(K_RED, nr, m); mm += m;
    for (int p = 0; p < 5; p++) begin
      want = 4'b0001 << (p % NA);
      total++;
      if (bus.green !== want || bus.cur_phase !== 2'(p % NA) || bus.phase_start !== 1'b1) begin
        bad++; $display("FAIL rr_order%0d: got g=%b cur=%0d ps=%b want g=%b", p, bus.green, bus.cur_phase, bus.phase_start, want);
      end
      if (p < 4) begin
        run_phase(K_GREEN, ng, m); mm += m;
        run_phase(K_AMBER, na, m); mm += m;
        run_phase(K_RED, nr, m); mm += m;
        total++;
        if (ng !== MAXG || na !== AMB || nr !== ART) begin
          bad++; $display("FAIL rr_ticks%0d: got %0d+%0d+%0d want %0d+%0d+%0d", p, ng, na, nr, MAXG, AMB, ART);
        end
      end
    end
    total++;
    if (mm !== 0) begin bad++; $display("FAIL rr_model: got %0d want 0", mm); end
  endtask

  task automatic test_preempt();
    int n, m, mm;
    do_reset();
    bus.req = 4'b0001;
    mm = 0;
    run_phase(K_RED, n, m); mm += m;
    run_ticks(2, m); mm += m;
    bus.preempt_valid = 1'b1; bus.preempt_id = 2'd2; bus.req = 4'b0010;
    cycle();
    if (obs_vec() !== exp_vec()) mm++;
    total++;
    if (bus.amber !== 4'b0001) begin bad++; $display("FAIL preempt_amber_now: got %b want 0001", bus.amber); end
    run_phase(K_AMBER, n, m); mm += m;
    total++;
    if (n !== AMB) begin bad++; $display("FAIL preempt_amber_len: got %0d want %0d", n, AMB); end
    run_phase(K_RED, n, m); mm += m;
    total++;
    if (bus.green !== 4'b0100 || bus.cur_phase !== 2'd2) begin
      bad++; $display("FAIL preempt_target: got g=%b cur=%0d want 0100 2", bus.green, bus.cur_phase);
    end
    run_ticks(30, m); mm += m;
    total++;
    if (bus.green !== 4'b0100) begin bad++; $display("FAIL preempt_hold: got %b want 0100", bus.green); end
    bus.preempt_valid = 1'b0;
    cycle();
    if (obs_vec() !== exp_vec()) mm++;
    total++;
    if (bus.amber !== 4'b0100) begin bad++; $display("FAIL preempt_release: got %b want 0100", bus.amber); end
    total++;
    if (mm !== 0) begin bad++; $display("FAIL preempt_model: got %0d want 0", mm); end
  endtask

  task automatic test_idle_reset();
    int n, m, mm;
    do_reset();
    mm = 0;
    run_ticks(2, m); mm += m;
    total++;
    if (bus.idle !== 1'b1 || bus.red !== 4'b1111) begin
      bad++; $display("FAIL idle_set: got idle=%b red=%b want 1 1111", bus.idle, bus.red);
    end
    run_ticks(3, m); mm += m;
    bus.req = 4'b1000;
    cycle();
    if (obs_vec() !== exp_vec()) mm++;
    total++;
    if (bus.green !== 4'b1000 || bus.cur_phase !== 2'd3 || bus.idle !== 1'b0) begin
      bad++; $display("FAIL idle_exit: got g=%b cur=%0d idle=%b want 1000 3 0", bus.green, bus.cur_phase, bus.idle);
    end
    bus.req = 4'b0001;
    run_phase(K_GREEN, n, m); mm += m;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    total++;
    if (obs_vec() !== RESET_V) begin bad++; $display("FAIL reset_in_amber: got %h want %h", obs_vec(), RESET_V); end
    run_phase(K_RED, n, m); mm += m;
    total++;
    if (n !== ART || bus.green !== 4'b0001) begin
      bad++; $display("FAIL reset_timer_clear: got ticks=%0d g=%b want %0d 0001", n, bus.green, ART);
    end
    total++;
    if (mm !== 0) begin bad++; $display("FAIL idle_model: got %0d want 0", mm); end
  endtask

  task automatic test_random();
    int shown;
    shown = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) begin
        bus.preempt_valid = ~bus.preempt_valid;
        bus.preempt_id = 2'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 499) == 0);
      bus.tick = ($urandom_range(0, 2) == 0);
      cycle();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        if (shown < 10) $display("FAIL random_cycle%0d: got %h want %h", i, obs_vec(), exp_vec());
        shown++;
      end
    end
    rst = 1'b0; bus.tick = 1'b0; bus.preempt_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.tick = 1'b0; bus.req = '0; bus.preempt_valid = 1'b0; bus.preempt_id = '0;
    test_reset();
    test_first_grant();
    test_gap_out();
    test_max_out();
    test_round_robin();
    test_preempt();
    test_idle_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Adaptive phase scheduler for the smart traffic light system. It arbitrates the single green right-of-way among N_APPR approaches using vehicle-presence requests and an emergency preemption input. It sequences each granted approach through GREEN, AMBER and ALL_RED with tick-based minimum, maximum, amber and clearance times. It sits between the sensor/debounce front end and the per-approach lamp drivers, and takes its time base from the timer module's one-cycle tick.

## Interface
- N_APPR, 4, number of approaches (≥2); ID_W = $clog2(N_APPR)
- CNT_W, 5, phase timer width
- MIN_GREEN, 5, minimum green in ticks
- MAX_GREEN, 15, maximum green in ticks when others are waiting
- AMBER_T, 3, amber duration in ticks
- ALL_RED_T, 2, all-red clearance in ticks
- Legal values: 1 ≤ MIN_GREEN ≤ MAX_GREEN < 2^CNT_W; AMBER_T ≥ 1; ALL_RED_T ≥ 1, both < 2^CNT_W

Ports:
- clk  in  1  system clock; one clock
- rst  in  1  reset; synchronous, active-high
- tick  in  1  one-cycle time-base strobe (nominally 1 s)
- req  in  N_APPR  level vehicle-presence request per approach
- preempt_valid  in  1  emergency preemption active (level)
- preempt_id  in  ID_W  approach to be preempted to green; ignored if ≥ N_APPR
- green  out  N_APPR  green lamp, at most one bit set
- amber  out  N_APPR  amber lamp, at most one bit set
- red  out  N_APPR  red lamp, equal to ~(green|amber)
- cur_phase  out  ID_W  last granted approach
- idle  out  1  in ALL_RED, clearance expired, no request
- phase_start  out  1  one-cycle pulse on every entry to GREEN

## Operation
- States: GREEN, AMBER, ALL_RED. Timer `t` (CNT_W) clears on every state entry and increments on `tick`.
- Reset:
  - state=ALL_RED, t=0, cur_phase=N_APPR-1, so round-robin starts at 0.
  - green=0, amber=0, red=all ones, idle=0, phase_start=0.
- Arbitration happens only in ALL_RED with t ≥ ALL_RED_T.
  - A valid preempt_id wins.
  - Otherwise the winner is the first set req bit searching cur_phase+1, cur_phase+2, … with wrap, ending at cur_phase itself.
  - On a win: go to GREEN, cur_phase=winner, phase_start=1.
  - With no request: stay in ALL_RED with idle=1, re-evaluate every cycle; no tick is needed to leave idle.
- GREEN on phase p: let `others` = req with bit p masked.
  - t saturates at MAX_GREEN.
  - Preempt active with preempt_id≠p: go to AMBER immediately, bypassing MIN_GREEN.
  - Preempt active with preempt_id==p: hold GREEN; max-out is disabled.
  - Otherwise go to AMBER when t ≥ MIN_GREEN and others≠0 and (req[p]==0 or t ≥ MAX_GREEN).
  - If others==0, rest in green indefinitely, including when req[p] drops.
- AMBER: go to ALL_RED when the AMBER_T-th tick arrives.
- ALL_RED: clearance ends when the ALL_RED_T-th tick arrives. Arbitration for a request present that cycle happens on the same edge, so ALL_RED goes straight to GREEN.
- Lamps are decoded from registered state and cur_phase; all outputs are registered.

## Timing
- All transitions occur on the clk edge at the end of the cycle in which the condition is true. The outputs reflect the new state in the following cycle.
- Tick-terminated states: the transition happens on the edge of the cycle carrying the N-th tick counted in that state. A tick in the entry cycle is not counted.
- GREEN exit conditions are evaluated every cycle, not only on tick. Latency from request or preempt change to state change is 1 edge.
- Simultaneous tick and exit condition: the transition wins and t clears.
- Preempt asserted during AMBER or ALL_RED does not shorten amber or clearance. It only steers the arbitration.
- preempt_valid deasserted mid-green: normal GREEN rules resume on the next cycle using the saturated t.
- rst mid-operation: reset values apply on the next edge, so all red within one cycle; phase_start=0.
- phase_start is high for exactly the first cycle of GREEN.

## Test plan
- Reset, then req=0001: green[0] rises after the 2nd tick and phase_start pulses once. With no other requests, green[0] stays high for 100 further ticks and amber stays 0.
- Gap-out: green[0] active, req[0] drops after 2 ticks, req[1]=1. Expect amber[0] on the edge of tick 5 (MIN_GREEN), then 3 ticks amber, 2 ticks all red, then green[1] with cur_phase=1.
- Max-out: req=0011 held constant. Expect green[0] for exactly 15 ticks, then amber[0], then green[1] for 15 ticks.
- Round robin: req=1111 constant from reset. Expect the green order 0,1,2,3,0 with 15+3+2 ticks per phase; red is always ~(green|amber).
- Preemption: green[0] at t=2, then preempt_valid=1 with preempt_id=2 and req=0010.
  - Expect amber[0] on the next edge.
  - After the amber and all-red times, expect green[2] (not 1).
  - green[2] holds for 30 ticks while preempt stays asserted, then exits after preempt_valid drops.
- Idle and reset: with req=0, after clearance expect idle=1 and all red. req[3] rising then gives green[3] one edge later. rst=1 during AMBER gives all red, state ALL_RED and t=0 on the next edge.
